// File: rtl/fetch_decode_unit_if.sv
// Fetch/decode bus: instruction-memory fetch port plus decoded IF/ID outputs.
// The master side is the fetch/decode unit; the slave side is the memory/register-file environment.
interface fetch_decode_unit_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 stall;
   logic [7:0]           instruction;
   logic [7:0]           pc;
   logic                 id_valid;
   logic [1:0]           id_opcode;
   logic [2:0]           id_rd;
   logic [7:0]           id_imm;
   logic                 id_we;
   logic                 jump_taken;
   logic [CNT_WIDTH-1:0] retired_count;

   modport master (
      input  stall, instruction,
      output pc, id_valid, id_opcode, id_rd, id_imm, id_we, jump_taken, retired_count
   );

   modport slave (
      output stall, instruction,
      input  pc, id_valid, id_opcode, id_rd, id_imm, id_we, jump_taken, retired_count
   );
endinterface

// File: rtl/fetch_decode_unit.sv
// Two-stage front end: combinational fetch from pc, then a one-entry IF/ID register
// with decode and relative-jump resolution (one squashed slot per taken jump).
module fetch_decode_unit #(
   parameter logic [7:0] RESET_PC  = 8'h00,
   parameter int         CNT_WIDTH = 16
) (
   input logic                 clk,
   input logic                 reset,
   fetch_decode_unit_if.master fdu
);
   typedef enum logic [1:0] {
      OP_LI   = 2'b00,
      OP_ADDI = 2'b01,
      OP_NOP  = 2'b10,
      OP_J    = 2'b11
   } opcode_t;

   logic [7:0]           pc_reg;
   logic [7:0]           ir;
   logic [7:0]           ir_pc;
   logic                 ir_valid;
   logic [CNT_WIDTH-1:0] retired;

   opcode_t    op;
   logic       jump;
   logic [7:0] jump_off;
   logic [7:0] jump_target;

   assign op          = opcode_t'(ir[7:6]);
   assign jump        = ir_valid && (op == OP_J);
   assign jump_off    = {{2{ir[5]}}, ir[5:0]};
   assign jump_target = ir_pc + 8'd1 + jump_off;

   // The slot fetched alongside a resolving jump is captured but marked dead.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg   <= RESET_PC;
         ir       <= 8'h80;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         retired  <= '0;
      end else if (!fdu.stall) begin
         ir       <= fdu.instruction;
         ir_pc    <= pc_reg;
         ir_valid <= !jump;
         pc_reg   <= jump ? jump_target : pc_reg + 8'd1;
         if (ir_valid && (retired != '1)) begin
            retired <= retired + 1'b1;
         end
      end
   end

   always_comb begin
      fdu.id_imm     = '0;
      fdu.id_we      = 1'b0;
      fdu.jump_taken = 1'b0;
      unique case (op)
         OP_LI: begin
            fdu.id_imm = {5'b0, ir[2:0]};
            fdu.id_we  = ir_valid;
         end
         OP_ADDI: begin
            fdu.id_imm = {{5{ir[2]}}, ir[2:0]};
            fdu.id_we  = ir_valid;
         end
         OP_J: begin
            fdu.id_imm     = jump_off;
            fdu.jump_taken = ir_valid;
         end
         OP_NOP: begin
            fdu.id_imm = '0;
         end
      endcase
   end

   assign fdu.pc            = pc_reg;
   assign fdu.id_valid      = ir_valid;
   assign fdu.id_opcode     = ir[7:6];
   assign fdu.id_rd         = ir[5:3];
   assign fdu.retired_count = retired;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench: a behavioural front-end model predicts every edge; a negedge monitor compares.
// A second instance with a 5-bit counter exercises retired_count saturation.
module tb_fetch_decode_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       stall;
   logic [7:0] mem [256];

   fetch_decode_unit_if #(.CNT_WIDTH(16)) bus_a ();
   fetch_decode_unit_if #(.CNT_WIDTH(5))  bus_b ();

   assign bus_a.stall       = stall;
   assign bus_b.stall       = stall;
   assign bus_a.instruction = mem[bus_a.pc];
   assign bus_b.instruction = mem[bus_b.pc];

   fetch_decode_unit #(.RESET_PC(8'h00), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .fdu(bus_a)
   );
   fetch_decode_unit #(.RESET_PC(8'h00), .CNT_WIDTH(5)) dut_b (
      .clk(clk), .reset(reset), .fdu(bus_b)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0]  pc;
      logic        v;
      logic [1:0]  op;
      logic [2:0]  rd;
      logic [7:0]  imm;
      logic        we;
      logic        jt;
      logic [15:0] cnt;
      logic [4:0]  cs;
   } exp_t;

   exp_t q[$];

   // Model: address/content of the instruction in D, its liveness, next fetch address, counts.
   int         m_pc, m_daddr, m_cnt, m_cs;
   logic [7:0] m_dinst;
   bit         m_dv;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int signed_field(input int val, input int bits);
      int half = 1 << (bits - 1);
      return (val >= half) ? val - 2 * half : val;
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      int ins = int'(m_dinst);
      int op  = ins / 64;
      int imm = 0;
      if (op == 0) imm = ins % 8;
      else if (op == 1) imm = signed_field(ins % 8, 3);
      else if (op == 3) imm = signed_field(ins % 64, 6);
      e.pc  = 8'(m_pc);
      e.v   = m_dv;
      e.op  = 2'(op);
      e.rd  = 3'((ins / 8) % 8);
      e.imm = 8'((imm + 256) % 256);
      e.we  = m_dv && (op < 2);
      e.jt  = m_dv && (op == 3);
      e.cnt = 16'(m_cnt);
      e.cs  = 5'(m_cs);
      return e;
   endfunction

   task automatic model_edge(input logic r, input logic s);
      int  ins, off, nxt;
      bit  jmp;
      if (r) begin
         m_pc = 0; m_dv = 0; m_dinst = 8'h80; m_daddr = 0; m_cnt = 0; m_cs = 0;
      end else if (!s) begin
         ins = int'(m_dinst);
         jmp = m_dv && (ins / 64 == 3);
         off = signed_field(ins % 64, 6);
         if (m_dv) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cs < 31) m_cs++;
         end
         nxt     = jmp ? (m_daddr + 1 + off + 256) % 256 : (m_pc + 1) % 256;
         m_dinst = mem[m_pc];
         m_daddr = m_pc;
         m_dv    = !jmp;
         m_pc    = nxt;
      end
   endtask

   task automatic cyc(input logic r, input logic s);
      reset = r;
      stall = s;
      model_edge(r, s);
      q.push_back(expect_now());
      @(posedge clk);
      #1;
   endtask

   task automatic fill_nops();
      for (int i = 0; i < 256; i++) mem[i] = 8'h80;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("pc", bus_a.pc, e.pc);
         check("id_valid", bus_a.id_valid, e.v);
         check("id_opcode", bus_a.id_opcode, e.op);
         check("id_rd", bus_a.id_rd, e.rd);
         check("id_imm", bus_a.id_imm, e.imm);
         check("id_we", bus_a.id_we, e.we);
         check("jump_taken", bus_a.jump_taken, e.jt);
         check("retired_count", bus_a.retired_count, e.cnt);
         check("pc_b", bus_b.pc, e.pc);
         check("retired_count_b", bus_b.retired_count, e.cs);
      end
   end

   initial begin
      reset = 1'b1;
      stall = 1'b0;

      // Memory image: li r6,3 / addi r6,2 / addi r4,3 / j +1 / li r4,4 / addi r4,-3
      fill_nops();
      mem[0] = 8'h33; mem[1] = 8'h72; mem[2] = 8'h63;
      mem[3] = 8'hC1; mem[4] = 8'h24; mem[5] = 8'h65;
      cyc(1, 0); cyc(1, 0);
      check("rst_valid", bus_a.id_valid, 0);
      check("rst_opcode", bus_a.id_opcode, 2);
      check("rst_imm", bus_a.id_imm, 0);
      cyc(0, 0);
      check("e1_rd", bus_a.id_rd, 6);
      check("e1_imm", bus_a.id_imm, 3);
      check("e1_we", bus_a.id_we, 1);
      cyc(0, 0); cyc(0, 0); cyc(0, 0);
      check("e4_jt", bus_a.jump_taken, 1);
      check("e4_imm", bus_a.id_imm, 8'h01);
      cyc(0, 0);
      check("e5_pc", bus_a.pc, 5);
      check("e5_valid", bus_a.id_valid, 0);
      cyc(0, 0);
      check("e6_rd", bus_a.id_rd, 4);
      check("e6_imm", bus_a.id_imm, 8'hFD);
      cyc(0, 0);
      check("e7_cnt", bus_a.retired_count, 5);

      // Stall three cycles with addi r6,2 in D
      cyc(1, 0); cyc(0, 0); cyc(0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1);
         check("stall_pc", bus_a.pc, 2);
         check("stall_imm", bus_a.id_imm, 2);
         check("stall_cnt", bus_a.retired_count, 1);
      end
      for (int i = 0; i < 5; i++) cyc(0, 0);

      // Jump wrap: 0 -> FE (j -3), FE -> 02 (j +3), 02 -> 01 (j -2), 01 -> FE (j -4)
      fill_nops();
      mem[0] = 8'hFD; mem[8'hFE] = 8'hC3; mem[2] = 8'hFE; mem[1] = 8'hFC;
      cyc(1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0);
      check("wrap_fwd_pc", bus_a.pc, 8'h02);
      for (int i = 0; i < 4; i++) cyc(0, 0);
      check("wrap_back_pc", bus_a.pc, 8'hFE);
      for (int i = 0; i < 6; i++) cyc(0, 0);

      // Self-loop at 8, reset under stall with the jump in D, then saturation of the small counter
      fill_nops();
      mem[0] = 8'hC7; mem[8] = 8'hFF;
      cyc(1, 0);
      cyc(0, 0); cyc(0, 0); cyc(0, 0);
      check("loop_jt", bus_a.jump_taken, 1);
      cyc(0, 1); cyc(0, 1);
      check("loop_stall_jt", bus_a.jump_taken, 1);
      check("loop_stall_pc", bus_a.pc, 9);
      cyc(1, 1);
      check("rst_mid_pc", bus_a.pc, 0);
      check("rst_mid_valid", bus_a.id_valid, 0);
      check("rst_mid_cnt", bus_a.retired_count, 0);
      check("rst_mid_jt", bus_a.jump_taken, 0);
      for (int i = 0; i < 90; i++) cyc(0, 0);
      check("sat_small", bus_b.retired_count, 31);
      check("wide_not_sat", (bus_a.retired_count > 31) ? 1 : 0, 1);

      // Random program, random stalls and occasional resets
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      cyc(1, 0);
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end

      @(negedge clk);
      #1;
      check("queue_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
